// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud generator: rate encodings, baud table,
// half-period computation and the per-channel state type.
package uart_pkg;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'b000,
        BAUD_19200  = 3'b001,
        BAUD_38400  = 3'b010,
        BAUD_57600  = 3'b011,
        BAUD_115200 = 3'b100
    } baud_sel_e;

    localparam int unsigned NUM_RATES = 5;
    localparam int unsigned BAUD_RATE [NUM_RATES] = '{9600, 19200, 38400, 57600, 115200};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } chan_state_e;

    // Unsupported selects fall back to the 9600 entry.
    function automatic int unsigned rate_index(input logic [2:0] sel);
        int unsigned idx;
        idx = 32'(sel);
        if (idx >= NUM_RATES) begin
            idx = 0;
        end
        return idx;
    endfunction

    function automatic logic [15:0] half_period(input int unsigned clk_freq,
                                                input logic [2:0] sel);
        int unsigned baud;
        baud = BAUD_RATE[rate_index(sel)];
        return 16'(clk_freq / (2 * baud));
    endfunction

endpackage

// File: rtl/uart_baud_channel.sv
// One baud clock channel: IDLE/LOW/HIGH FSM producing a registered bit clock
// that idles high and always completes a started period.
module uart_baud_channel
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_sel,
    input  logic       enable,
    output logic       clk_uart,
    output logic       busy
);

    localparam logic [15:0] H_TAB [NUM_RATES] = '{
        half_period(CLK_FREQ, BAUD_9600),
        half_period(CLK_FREQ, BAUD_19200),
        half_period(CLK_FREQ, BAUD_38400),
        half_period(CLK_FREQ, BAUD_57600),
        half_period(CLK_FREQ, BAUD_115200)
    };

    function automatic logic [15:0] reload(input logic [2:0] sel);
        return H_TAB[rate_index(sel)] - 16'd1;
    endfunction

    chan_state_e state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [2:0]  rate_q, rate_d;
    logic        out_d, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            rate_q   <= '0;
            clk_uart <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rate_q   <= rate_d;
            clk_uart <= out_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rate_d  = rate_q;
        case (state_q)
            ST_IDLE: begin
                // The first period uses the live select, which is also latched this edge.
                rate_d  = baud_sel;
                count_d = '0;
                if (enable) begin
                    state_d = ST_LOW;
                    count_d = reload(baud_sel);
                end
            end
            ST_LOW: begin
                if (count_q == '0) begin
                    state_d = ST_HIGH;
                    count_d = reload(rate_q);
                end else begin
                    count_d = count_q - 16'd1;
                end
            end
            ST_HIGH: begin
                if (count_q == '0) begin
                    if (enable) begin
                        state_d = ST_LOW;
                        count_d = reload(rate_q);
                    end else begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
        out_d  = (state_d != ST_LOW);
        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator top: tx channel always present, rx channel only when
// UART_BAUD_GEN_RX_EN is defined (otherwise rx outputs are tied idle).
module uart_baud_gen #(
    parameter int unsigned CLK_FREQ = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_sel,
    input  logic       uart_enable_tx,
    input  logic       uart_enable_rx,
    output logic       clk_uart_tx,
    output logic       clk_uart_rx,
    output logic       busy_tx,
    output logic       busy_rx
);

    uart_baud_channel #(.CLK_FREQ(CLK_FREQ)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .baud_sel (baud_sel),
        .enable   (uart_enable_tx),
        .clk_uart (clk_uart_tx),
        .busy     (busy_tx)
    );

`ifdef UART_BAUD_GEN_RX_EN
    uart_baud_channel #(.CLK_FREQ(CLK_FREQ)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .baud_sel (baud_sel),
        .enable   (uart_enable_rx),
        .clk_uart (clk_uart_rx),
        .busy     (busy_rx)
    );
`else
    logic unused_rx_enable;
    assign unused_rx_enable = uart_enable_rx;
    assign clk_uart_rx      = 1'b1;
    assign busy_rx          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen at 100 MHz: per-rate period table plus
// hand-written sequences for hold, mid-run select change, restart and reset.
module tb_uart_baud_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] baud_sel = 3'b000;
    logic       uart_enable_tx = 1'b0;
    logic       uart_enable_rx = 1'b0;
    logic       clk_uart_tx, clk_uart_rx, busy_tx, busy_rx;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    typedef struct {
        logic [2:0]  sel;
        int unsigned h;
        string       name;
    } vec_t;

    vec_t vecs [6];

    uart_baud_gen #(.CLK_FREQ(100000000)) dut (
        .clk            (clk),
        .rst            (rst),
        .baud_sel       (baud_sel),
        .uart_enable_tx (uart_enable_tx),
        .uart_enable_rx (uart_enable_rx),
        .clk_uart_tx    (clk_uart_tx),
        .clk_uart_rx    (clk_uart_rx),
        .busy_tx        (busy_tx),
        .busy_rx        (busy_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic out_of(input int ch);
        return (ch == 0) ? clk_uart_tx : clk_uart_rx;
    endfunction

    function automatic logic busy_of(input int ch);
        return (ch == 0) ? busy_tx : busy_rx;
    endfunction

    task automatic set_en(input int ch, input logic v);
        if (ch == 0) uart_enable_tx = v;
        else uart_enable_rx = v;
    endtask

    // Counts consecutive observed cycles at 'level' while the channel is busy.
    task automatic count_while(input int ch, input logic level, output int unsigned n);
        n = 0;
        while (out_of(ch) == level && busy_of(ch) && n < 20000) begin
            n++;
            tick();
        end
    endtask

    task automatic run_pulse(input int ch, input logic [2:0] sel, input int unsigned h,
                             input string name);
        int unsigned n;
        baud_sel = sel;
        set_en(ch, 1'b1);
        tick();
        set_en(ch, 1'b0);
        check({name, "_fall"}, out_of(ch), 0);
        check({name, "_busy"}, busy_of(ch), 1);
        count_while(ch, 1'b0, n);
        check({name, "_low"}, n, h);
        count_while(ch, 1'b1, n);
        check({name, "_high"}, n, h);
        check({name, "_idle_busy"}, busy_of(ch), 0);
        check({name, "_idle_out"}, out_of(ch), 1);
    endtask

    initial begin
        int unsigned n;
        int unsigned bad;

        vecs[0] = '{3'b000, 5208, "sel000"};
        vecs[1] = '{3'b001, 2604, "sel001"};
        vecs[2] = '{3'b010, 1302, "sel010"};
        vecs[3] = '{3'b011,  868, "sel011"};
        vecs[4] = '{3'b100,  434, "sel100"};
        vecs[5] = '{3'b101, 5208, "sel101"};

        #1 rst = 1'b1;
        #2;
        check("rst_tx_out", clk_uart_tx, 1);
        check("rst_rx_out", clk_uart_rx, 1);
        check("rst_tx_busy", busy_tx, 0);
        check("rst_rx_busy", busy_rx, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_tx_out", clk_uart_tx, 1);

        for (int i = 0; i < 6; i++) begin
            run_pulse(0, vecs[i].sel, vecs[i].h, vecs[i].name);
            tick();
        end

        // Held enable, then dropped mid low phase of the second period.
        baud_sel = 3'b100;
        uart_enable_tx = 1'b1;
        tick();
        check("hold_fall", clk_uart_tx, 0);
        count_while(0, 1'b0, n);
        check("hold_low1", n, 434);
        count_while(0, 1'b1, n);
        check("hold_high1", n, 434);
        check("hold_busy", busy_tx, 1);
        for (int i = 0; i < 100; i++) tick();
        uart_enable_tx = 1'b0;
        count_while(0, 1'b0, n);
        check("drop_low_rest", n, 334);
        count_while(0, 1'b1, n);
        check("drop_high", n, 434);
        check("drop_idle_busy", busy_tx, 0);
        tick();

        // Select change while busy does not affect the running channel.
        baud_sel = 3'b100;
        uart_enable_tx = 1'b1;
        tick();
        count_while(0, 1'b0, n);
        check("sw_low1", n, 434);
        baud_sel = 3'b000;
        count_while(0, 1'b1, n);
        check("sw_high1", n, 434);
        count_while(0, 1'b0, n);
        check("sw_low2", n, 434);
        uart_enable_tx = 1'b0;
        count_while(0, 1'b1, n);
        check("sw_high2", n, 434);
        check("sw_idle", busy_tx, 0);
        run_pulse(0, 3'b000, 5208, "sw_next");

        // Re-enable in the first IDLE cycle restarts on the next edge.
        tick();
        baud_sel = 3'b100;
        uart_enable_tx = 1'b1;
        tick();
        uart_enable_tx = 1'b0;
        count_while(0, 1'b0, n);
        count_while(0, 1'b1, n);
        check("re_idle_busy", busy_tx, 0);
        check("re_idle_out", clk_uart_tx, 1);
        uart_enable_tx = 1'b1;
        tick();
        uart_enable_tx = 1'b0;
        check("re_fall", clk_uart_tx, 0);
        count_while(0, 1'b0, n);
        check("re_low", n, 434);
        count_while(0, 1'b1, n);
        check("re_high", n, 434);

        // Asynchronous reset in the middle of a low phase.
        tick();
        baud_sel = 3'b100;
        uart_enable_tx = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        check("mid_low_out", clk_uart_tx, 0);
        rst = 1'b1;
        uart_enable_tx = 1'b0;
        #1;
        check("async_rst_out", clk_uart_tx, 1);
        check("async_rst_busy", busy_tx, 0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (clk_uart_tx != 1'b1 || busy_tx != 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);
        run_pulse(0, 3'b100, 434, "post_rst_run");

`ifdef UART_BAUD_GEN_RX_EN
        tick();
        run_pulse(1, 3'b000, 5208, "rx_pulse");
        tick();
        // Concurrent channels at different rates; rx starts one cycle after tx.
        baud_sel = 3'b100;
        uart_enable_tx = 1'b1;
        tick();
        baud_sel = 3'b011;
        uart_enable_rx = 1'b1;
        fork
            begin
                int unsigned m;
                count_while(0, 1'b0, m);
                check("cc_tx_low1", m, 434);
                count_while(0, 1'b1, m);
                check("cc_tx_high1", m, 434);
                uart_enable_tx = 1'b0;
                count_while(0, 1'b0, m);
                check("cc_tx_low2", m, 434);
                count_while(0, 1'b1, m);
                check("cc_tx_high2", m, 434);
                check("cc_tx_idle", busy_tx, 0);
            end
            begin
                int unsigned m;
                tick();
                uart_enable_rx = 1'b0;
                check("cc_rx_fall", clk_uart_rx, 0);
                count_while(1, 1'b0, m);
                check("cc_rx_low", m, 868);
                count_while(1, 1'b1, m);
                check("cc_rx_high", m, 868);
                check("cc_rx_idle", busy_rx, 0);
            end
        join
`else
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            baud_sel = 3'(i % 5);
            uart_enable_rx = i[1];
            tick();
            if (clk_uart_rx != 1'b1 || busy_rx != 1'b0) bad++;
        end
        uart_enable_rx = 1'b0;
        check("rx_absent_quiet", bad, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
